// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN enables the madd/maddu/msub/msubu ops (9-12).
package mdu_pkg;

    localparam int unsigned OP_W            = 4;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [OP_W-1:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Ops that take the multiplier latency (accumulate family only when built in)
    function automatic logic is_mult_op(input logic [OP_W-1:0] op);
`ifdef MDU_MADD_EN
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
    import mdu_pkg::*;

    logic              Start;
    logic [OP_W-1:0]   MDUOp;
    logic [DATA_W-1:0] SA;
    logic [DATA_W-1:0] SB;
    logic              Req;
    logic              Busy;
    logic [DATA_W-1:0] MDUOut;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    modport master (output Start, MDUOp, SA, SB, Req, input Busy, MDUOut, HI, LO);
    modport slave  (input Start, MDUOp, SA, SB, Req, output Busy, MDUOut, HI, LO);
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit product / quotient / remainder / accumulate datapath.
// Accumulate ops exist only with MDU_MADD_EN defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] res_hi_c,
    output logic [DATA_W-1:0] res_lo_c,
    output logic              wr_en_c
);

    logic signed [63:0] a_s, b_s;
    logic [63:0]        prod_s, prod_u, acc, res;
    logic signed [32:0] a33, b33, q33, r33;
    logic [DATA_W-1:0]  div_u, q_u, r_u;
    logic               b_zero;
    logic               unused_bits;

    assign a_s    = {{32{a[31]}}, a};
    assign b_s    = {{32{b[31]}}, b};
    assign prod_s = a_s * b_s;
    assign prod_u = {32'b0, a} * {32'b0, b};
    assign acc    = {hi, lo};
    assign b_zero = (b == '0);

    // 33-bit signed divide so that -2^31 / -1 cannot overflow
    assign a33 = {a[31], a};
    assign b33 = b_zero ? 33'sd1 : {b[31], b};
    assign q33 = a33 / b33;
    assign r33 = a33 % b33;

    assign div_u = b_zero ? 32'd1 : b;
    assign q_u   = a / div_u;
    assign r_u   = a % div_u;

    assign unused_bits = ^{q33[32], r33[32]};

    always_comb begin
        res     = acc;
        wr_en_c = 1'b0;
        case (op)
            OP_MULT:  begin res = prod_s; wr_en_c = 1'b1; end
            OP_MULTU: begin res = prod_u; wr_en_c = 1'b1; end
            OP_DIV:   begin res = {r33[31:0], q33[31:0]}; wr_en_c = !b_zero; end
            OP_DIVU:  begin res = {r_u, q_u}; wr_en_c = !b_zero; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin res = acc + prod_s; wr_en_c = 1'b1; end
            OP_MADDU: begin res = acc + prod_u; wr_en_c = 1'b1; end
            OP_MSUB:  begin res = acc - prod_s; wr_en_c = 1'b1; end
            OP_MSUBU: begin res = acc - prod_u; wr_en_c = 1'b1; end
`endif
            default:  begin res = acc; wr_en_c = 1'b0; end
        endcase
    end

    assign res_hi_c = res[63:32];
    assign res_lo_c = res[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: IDLE/RUN FSM, latency counter, HI/LO registers.
// Build option MDU_MADD_EN adds the madd/maddu/msub/msubu ops.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] res_hi_c, res_lo_c, mdu_out_c;
    logic              wr_en_c, issue_c;

    mdu_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .hi       (hi_q),
        .lo       (lo_q),
        .res_hi_c (res_hi_c),
        .res_lo_c (res_lo_c),
        .wr_en_c  (wr_en_c)
    );

    assign issue_c = bus.Start && !bus.Req;

    // Next-state: issue from IDLE, count down in RUN, commit on the last Busy cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    if (is_mult_op(bus.MDUOp) || is_div_op(bus.MDUOp)) begin
                        state_d = ST_RUN;
                        cnt_d   = is_div_op(bus.MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        a_d     = bus.SA;
                        b_d     = bus.SB;
                        op_d    = bus.MDUOp;
                    end else if (bus.MDUOp == OP_MTHI) begin
                        hi_d = bus.SA;
                    end else if (bus.MDUOp == OP_MTLO) begin
                        lo_d = bus.SA;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (wr_en_c) begin
                        hi_d = res_hi_c;
                        lo_d = res_lo_c;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        mdu_out_c = '0;
        case (bus.MDUOp)
            OP_MFHI: mdu_out_c = hi_q;
            OP_MFLO: mdu_out_c = lo_q;
            default: mdu_out_c = '0;
        endcase
    end

    assign bus.Busy   = (state_q == ST_RUN);
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.MDUOut = mdu_out_c;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized traffic vs. a behavioural model.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mdu_if u_if();

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural HI/LO plus remaining busy cycles of a pending op
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [3:0]  m_op;
    int          m_left;

    function automatic logic [64:0] calc(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
        longint sa, sb, sp, q, r;
        logic [63:0] up, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sp  = sa * sb;
        up  = 64'(a) * 64'(b);
        acc = {hi, lo};
        case (op)
            4'd1: return {1'b1, 64'(sp)};
            4'd2: return {1'b1, up};
            4'd3: begin
                if (b == 0) return {1'b0, acc};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return {1'b0, acc};
                return {1'b1, a % b, a / b};
            end
            4'd9:  return {1'b1, acc + 64'(sp)};
            4'd10: return {1'b1, acc + up};
            4'd11: return {1'b1, acc - 64'(sp)};
            4'd12: return {1'b1, acc - up};
            default: return {1'b0, acc};
        endcase
    endfunction

    task automatic model_clear();
        m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = 0; m_left = 0;
    endtask

    task automatic model_step();
        logic [64:0] r;
        logic [3:0]  op;
        op = u_if.MDUOp;
        if (reset) begin
            model_clear();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                r = calc(m_op, m_a, m_b, m_hi, m_lo);
                if (r[64]) {m_hi, m_lo} = r[63:0];
            end
        end else if (u_if.Start && !u_if.Req) begin
            if (op == 1 || op == 2 || (MADD && op >= 9 && op <= 12)) begin
                m_left = MULT_N; m_op = op; m_a = u_if.SA; m_b = u_if.SB;
            end else if (op == 3 || op == 4) begin
                m_left = DIV_N; m_op = op; m_a = u_if.SA; m_b = u_if.SB;
            end else if (op == 7) begin
                m_hi = u_if.SA;
            end else if (op == 8) begin
                m_lo = u_if.SA;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [31:0] exp_out;
        exp_out = (u_if.MDUOp == 4'd5) ? m_hi : (u_if.MDUOp == 4'd6) ? m_lo : 32'd0;
        check("cyc_busy",   32'(u_if.Busy), 32'(m_left > 0));
        check("cyc_hi",     u_if.HI, m_hi);
        check("cyc_lo",     u_if.LO, m_lo);
        check("cyc_mduout", u_if.MDUOut, exp_out);
    end

    task automatic cyc(input logic r, input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic rq);
        reset = r; u_if.Start = st; u_if.MDUOp = op; u_if.SA = a; u_if.SB = b; u_if.Req = rq;
        if (r) model_clear();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (u_if.Busy === 1'b1 && n < 40) begin
            n++;
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int n;
        model_clear();
        reset = 1'b1; u_if.Start = 0; u_if.MDUOp = 0; u_if.SA = 0; u_if.SB = 0; u_if.Req = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_busy", 32'(u_if.Busy), 32'd0);
        check("rst_hi", u_if.HI, 32'd0);
        check("rst_mduout", u_if.MDUOut, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // signed multiply
        cyc(0, 1, 4'd1, 32'hFFFF_FFFE, 32'd3, 0);
        wait_idle(n);
        check("mult_busy_cycles", 32'(n), 32'd5);
        check("mult_hi", u_if.HI, 32'hFFFF_FFFF);
        check("mult_lo", u_if.LO, 32'hFFFF_FFFA);
        check("model_mult_lo", m_lo, 32'hFFFF_FFFA);

        // unsigned and signed divide
        cyc(0, 1, 4'd4, 32'd100, 32'd7, 0);
        wait_idle(n);
        check("divu_busy_cycles", 32'(n), 32'd10);
        check("divu_hi", u_if.HI, 32'd2);
        check("divu_lo", u_if.LO, 32'd14);
        cyc(0, 1, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        wait_idle(n);
        check("div_hi", u_if.HI, 32'hFFFF_FFFF);
        check("div_lo", u_if.LO, 32'hFFFF_FFFD);
        check("model_div_hi", m_hi, 32'hFFFF_FFFF);

        // divide by zero leaves HI/LO alone
        cyc(0, 1, 4'd7, 32'h11, 0, 0);
        cyc(0, 1, 4'd8, 32'h22, 0, 0);
        cyc(0, 1, 4'd3, 32'd5, 32'd0, 0);
        wait_idle(n);
        check("div0_busy_cycles", 32'(n), 32'd10);
        check("div0_hi", u_if.HI, 32'h11);
        check("div0_lo", u_if.LO, 32'h22);

        // flush suppresses issue
        cyc(0, 1, 4'd1, 32'd5, 32'd6, 1);
        check("req_busy", 32'(u_if.Busy), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check("req_hi", u_if.HI, 32'h11);

        // run survives flush and new Starts
        cyc(0, 1, 4'd1, 32'hFFFF_FFFE, 32'd3, 0);
        cyc(0, 1, 4'd1, 32'd9, 32'd9, 0);
        cyc(0, 1, 4'd4, 32'd3, 32'd3, 1);
        wait_idle(n);
        check("hazard_busy_left", 32'(n), 32'd3);
        check("hazard_hi", u_if.HI, 32'hFFFF_FFFF);
        check("hazard_lo", u_if.LO, 32'hFFFF_FFFA);

        // mthi then mfhi
        cyc(0, 1, 4'd7, 32'hABCD, 0, 0);
        cyc(0, 1, 4'd5, 0, 0, 0);
        check("mfhi_out", u_if.MDUOut, 32'hABCD);

        // signed overflow corner
        cyc(0, 1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        wait_idle(n);
        check("divovf_lo", u_if.LO, 32'h8000_0000);
        check("divovf_hi", u_if.HI, 32'd0);

        // reset mid divide
        cyc(0, 1, 4'd8, 32'h55, 0, 0);
        cyc(0, 1, 4'd3, 32'd50, 32'd3, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_clear();
        #1;
        check("midrst_busy", 32'(u_if.Busy), 32'd0);
        check("midrst_hi", u_if.HI, 32'd0);
        check("midrst_lo", u_if.LO, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

`ifdef MDU_MADD_EN
        cyc(0, 1, 4'd7, 32'd0, 0, 0);
        cyc(0, 1, 4'd8, 32'hFFFF_FFFF, 0, 0);
        cyc(0, 1, 4'd9, 32'd1, 32'd1, 0);
        wait_idle(n);
        check("madd_busy_cycles", 32'(n), 32'd5);
        check("madd_hi", u_if.HI, 32'd1);
        check("madd_lo", u_if.LO, 32'd0);
`else
        cyc(0, 1, 4'd7, 32'h77, 0, 0);
        cyc(0, 1, 4'd9, 32'd1, 32'd1, 0);
        check("madd_undef_busy", 32'(u_if.Busy), 32'd0);
        check("madd_undef_hi", u_if.HI, 32'h77);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            logic [3:0]  op;
            op = (($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8)));
            a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) - 32'd150 : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            cyc(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1, op, a, b,
                $urandom_range(0, 7) == 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        wait_idle(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, Busy cycles for mult/multu (and madd family when enabled).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, Busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  EX-stage multiply/divide or move-to instruction present this cycle.
REQ-006 SHALL have port MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-12 madd/maddu/msub/msubu.
REQ-007 SHALL have port SA  input  32  operand rs.
REQ-008 SHALL have port SB  input  32  operand rt.
REQ-009 SHALL have port Req  input  1  exception/interrupt flush from CP0; cancels the EX-stage instruction.
REQ-010 SHALL have port Busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port MDUOut  output  32  HI for op 5, LO for op 6, else 0.
REQ-012 SHALL have port HI  output  32  current HI register.
REQ-013 SHALL have port LO  output  32  current LO register.

Function
REQ-014 SHALL implement states IDLE and RUN with a 4-bit down-counter; Busy = (state == RUN).
REQ-015 SHALL, in IDLE with Start=1, Req=0 and MDUOp in 1-4 (9-12 if enabled), latch SA/SB/op, load counter with MULT_CYCLES or DIV_CYCLES, enter RUN next edge.
REQ-016 SHALL keep Busy high exactly N cycles (N = loaded latency), starting the cycle after Start.
REQ-017 SHALL write HI/LO on the edge ending the last Busy cycle, return to IDLE on the same edge; results visible the cycle Busy falls.
REQ-018 SHALL compute mult as signed 64-bit {HI,LO}=SA*SB; multu unsigned.
REQ-019 SHALL compute div as signed LO=quotient, HI=remainder (sign of dividend, truncation toward zero); divu unsigned.
REQ-020 SHALL leave HI and LO unchanged when the divisor is zero; Busy still asserts DIV_CYCLES.
REQ-021 SHALL write HI (op 7) or LO (op 8) from SA at the next edge when Start=1, Req=0, Busy=0; no Busy assertion.
REQ-022 SHALL drive MDUOut combinationally from current HI/LO per MDUOp.
REQ-023 SHALL ignore Start of any op while Busy=1 (the hazard unit stalls the issuer).
REQ-024 SHALL suppress every Start (ops 1-12) in a cycle where Req=1; an already-running operation SHALL complete unaffected.
REQ-025 SHALL ignore undefined MDUOp values (13-15): no state change.

Reset
REQ-026 SHALL on reset asynchronously set state IDLE, counter 0, HI 0, LO 0, latched operands 0; Busy=0, MDUOut=0.
REQ-027 SHALL abort any RUN operation on reset without writing HI/LO.

Configuration
REQ-028 SHALL with MDU_MADD_EN defined support ops 9-12: {HI,LO} += or -= (signed 9/11, unsigned 10/12) 64-bit product, MULT_CYCLES latency, wrap modulo 2^64.
REQ-029 SHALL without MDU_MADD_EN treat ops 9-12 as undefined per REQ-025.

Structure
REQ-030 SHALL place MDUOp encodings, state encoding and default latencies in shared package mdu_pkg.
REQ-031 SHALL isolate 64-bit product/quotient/remainder/accumulate math in combinational sub-module mdu_arith; mdu_ctrl holds FSM, counter, HI/LO.

Verification
REQ-032 mult SA=0xFFFFFFFE, SB=3 -> Busy high cycles 1-5, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 divu SA=100, SB=7 -> Busy 10 cycles, then HI=2, LO=14; div SA=-7, SB=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-034 div SB=0 with HI=0x11, LO=0x22 -> Busy 10 cycles, HI/LO unchanged.
REQ-035 mult issued with Req=1 -> Busy stays 0, HI/LO unchanged; Req=1 during RUN -> operation completes normally.
REQ-036 mthi SA=0xABCD then mfhi -> MDUOut=0xABCD next cycle; Start mult during Busy -> ignored, first result intact.
REQ-037 reset asserted mid-div at cycle 4 -> Busy=0 immediately, HI=LO=0; with MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, madd 1*1 -> HI=1, LO=0.
